ps2_tx: RTL and testbench



---
 rtl/ps2_tx_pkg.sv | 27 ++
 rtl/ps2_line_filter.sv | 34 +++
 rtl/ps2_tx.sv | 125 ++++++++++++
 tb/tb_ps2_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg: shared definitions for the PS/2 host transmitter and line filter.
//   FSM state encoding, default timing parameters, PS/2 command constants and
//   a small elaboration helper.
package ps2_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RTS      = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_STOP     = 3'd4,
        ST_WAIT_REL = 3'd5
    } state_t;

    localparam int DEF_INHIBIT_CYCLES = 6000;
    localparam int DEF_FILTER_LEN     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: debounces one PS/2 line and strobes its falling edge.
//   clk, reset : system clock, asynchronous active-high reset
//   line_in    : raw (asynchronous) line level
//   level      : filtered level; changes only after FILTER_LEN identical samples
//   fall       : one-cycle strobe when level goes 1->0
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic [FILTER_LEN-1:0] sr;
    logic                  level_next;

    assign level_next = &sr ? 1'b1 : ~|sr ? 1'b0 : level;

    // Idle PS/2 lines float high, so the history starts full of ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr    <= '1;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sr    <= {sr[FILTER_LEN-2:0], line_in};
            level <= level_next;
            fall  <= level & ~level_next;
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter with open-drain line drivers.
//   clk, reset   : system clock, asynchronous active-high reset
//   wr_ps2, din  : start request and byte to send (taken only while tx_idle)
//   ps2c, ps2d   : shared PS/2 clock/data, driven 0 or Z only
//   tx_idle      : lines are free for the receiver
//   tx_done_tick : transfer finished, lines released
//   ack_err      : device did not acknowledge (coincides with tx_done_tick)
// Optional macro PS2_TX_TIMEOUT_EN adds a device-clock watchdog.
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    // One counter serves the request-to-send hold and, after it, the watchdog.
    localparam int CNT_W = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);

    state_t           state, state_next;
    logic [8:0]       frame, frame_next;
    logic [3:0]       n, n_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             nack, nack_next;
    logic             c_low, d_low;
    logic             c_lvl, c_fall, d_lvl, unused_d_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk(clk), .reset(reset), .line_in(ps2c), .level(c_lvl), .fall(c_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk(clk), .reset(reset), .line_in(ps2d), .level(d_lvl), .fall(unused_d_fall)
    );

    assign ps2c    = c_low ? 1'b0 : 1'bz;
    assign ps2d    = d_low ? 1'b0 : 1'bz;
    assign tx_idle = state == ST_IDLE;

    always_comb begin
        state_next   = state;
        frame_next   = frame;
        n_next       = n;
        cnt_next     = cnt;
        nack_next    = nack;
        tx_done_tick = 1'b0;
        ack_err      = 1'b0;
        case (state)
            ST_IDLE: if (wr_ps2) begin
                frame_next = {~^din, din};
                cnt_next   = CNT_W'(INHIBIT_CYCLES - 1);
                state_next = ST_RTS;
            end
            ST_RTS: begin
                cnt_next   = cnt == '0 ? cnt : cnt - 1'b1;
                state_next = cnt == '0 ? ST_START : ST_RTS;
            end
            ST_START: if (c_fall) begin
                n_next     = 4'd8;
                state_next = ST_DATA;
            end
            ST_DATA: if (c_fall) begin
                // n reaching 0 means parity is already on the wire; next is stop.
                if (n == '0) state_next = ST_STOP;
                else begin
                    frame_next = frame >> 1;
                    n_next     = n - 1'b1;
                end
            end
            ST_STOP: if (c_fall) begin
                nack_next  = d_lvl;
                state_next = ST_WAIT_REL;
            end
            ST_WAIT_REL: if (c_lvl && d_lvl) begin
                tx_done_tick = 1'b1;
                ack_err      = nack;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (state == ST_RTS && cnt == '0) cnt_next = CNT_W'(TIMEOUT_CYCLES);
        else if (state != ST_IDLE && state != ST_RTS) begin
            cnt_next = c_fall ? CNT_W'(TIMEOUT_CYCLES) : cnt - 1'b1;
            if (cnt == '0) begin
                tx_done_tick = 1'b1;
                ack_err      = 1'b1;
                state_next   = ST_IDLE;
            end
        end
`endif
    end

    // Line enables are registered from the next state so they never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            frame <= '0;
            n     <= '0;
            cnt   <= '0;
            nack  <= 1'b0;
            c_low <= 1'b0;
            d_low <= 1'b0;
        end else begin
            state <= state_next;
            frame <= frame_next;
            n     <= n_next;
            cnt   <= cnt_next;
            nack  <= nack_next;
            c_low <= state_next == ST_RTS;
            d_low <= state_next == ST_START || (state_next == ST_DATA && !frame_next[0]);
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: scoreboard bench for ps2_tx with a PS/2 device model on open-drain lines.
module tb_ps2_tx;
    import ps2_tx_pkg::*;

    localparam int HALF = 150;

    typedef struct packed {
        logic [7:0] data;
        logic       parity;
        logic       nack;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       tx_idle, tx_done_tick, ack_err;
    logic [9:0] bits;
    wire        ps2c, ps2d;
    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;

    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    ps2_tx dut (
        .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din), .ps2c(ps2c), .ps2d(ps2d),
        .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] d, input logic nack);
        int n;
        wr_ps2 = 1'b1;
        din    = d;
        sb.push_back('{d, ~^d, nack});
        cyc(1);
        wr_ps2 = 1'b0;
        check("rts_latency", ps2c, 0);
        check("busy", tx_idle, 0);
        n = 0;
        while (ps2c == 1'b0 && n < 7000) begin
            n++;
            cyc(1);
        end
        check("rts_len", n, 6000);
        check("start_bit", ps2d, 0);
    endtask

    task automatic bfm(input logic ack, input int glitch_at, input int abort_at,
                       output logic [9:0] b);
        b = '0;
        cyc(50);
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && ack) begin
                dev_d_low = 1'b1;
                cyc(50);
            end
            dev_c_low = 1'b1;
            if (i == abort_at) return;
            cyc(HALF);
            dev_c_low = 1'b0;
            if (i == 10) begin
                dev_d_low = 1'b0;
                return;
            end
            b[i] = ps2d;
            if (i == glitch_at) begin
                cyc(50);
                dev_c_low = 1'b1;
                cyc(3);
                dev_c_low = 1'b0;
                cyc(HALF - 53);
            end else cyc(HALF);
        end
    endtask

    task automatic finish_tx(input logic [9:0] b);
        exp_t e;
        bit   seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (tx_done_tick) seen = 1;
            else cyc(1);
        end
        check("done_seen", seen, 1);
        if (!seen) return;
        check("idle_at_done", tx_idle, 0);
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("data", b[7:0], e.data);
        check("parity", b[8], e.parity);
        check("stop", b[9], 1);
        check("ack_err", ack_err, e.nack);
        cyc(1);
        check("idle_after", tx_idle, 1);
        check("done_pulse", tx_done_tick, 0);
        check("lines_rel", {ps2c, ps2d}, 2'b11);
    endtask

    initial begin
        cyc(3);
        check("rst_idle", tx_idle, 1);
        check("rst_done", tx_done_tick, 0);
        check("rst_ackerr", ack_err, 0);
        check("rst_lines", {ps2c, ps2d}, 2'b11);
        reset = 1'b0;
        cyc(20);

        start_tx(CMD_SET_LEDS, 1'b0);
        bfm(1'b1, -1, -1, bits);
        check("ed_bits", bits, 10'b11_1110_1101);
        finish_tx(bits);
        cyc(20);

        start_tx(8'h00, 1'b1);
        bfm(1'b0, -1, -1, bits);
        finish_tx(bits);
        cyc(20);

        start_tx(CMD_RESET, 1'b0);
        fork
            bfm(1'b1, -1, -1, bits);
            begin
                cyc(1500);
                check("busy_mid", tx_idle, 0);
                wr_ps2 = 1'b1;
                din    = 8'h55;
                cyc(1);
                wr_ps2 = 1'b0;
            end
        join
        finish_tx(bits);
        check("sb_empty", sb.size(), 0);
        cyc(20);

        start_tx(8'h00, 1'b0);
        bfm(1'b1, -1, 4, bits);
        check("pre_reset_d", ps2d, 0);
        reset = 1'b1;
        #1;
        check("reset_d_rel", ps2d, 1);
        check("reset_idle", tx_idle, 1);
        dev_c_low = 1'b0;
        cyc(3);
        check("reset_c_rel", ps2c, 1);
        reset = 1'b0;
        sb.delete();
        cyc(20);

        start_tx(CMD_RESET, 1'b0);
        bfm(1'b1, -1, -1, bits);
        finish_tx(bits);
        cyc(20);

        start_tx(8'h3C, 1'b0);
        bfm(1'b1, 3, -1, bits);
        finish_tx(bits);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
